// File: rtl/mult_rs.sv
// Four-entry reservation station for the multiply unit: captures operands at dispatch or from the CDB,
// and issues the oldest ready op into the multiply FU with a mandatory idle cycle after each issue.
module mult_rs #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        dispatch_valid,
    output logic        dispatch_ready,
    input  logic [7:0]  d_operand,
    input  logic [1:0]  d_src_ready,
    input  logic [7:0]  d_src_tag,
    input  logic [15:0] d_src_val,
    input  logic [7:0]  d_wbs,
    input  logic [7:0]  d_flags,
    input  logic [3:0]  d_robid,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_id,
    input  logic [7:0]  cdb_val,
    input  logic        fu_busy,
    output logic        issue_transmit,
    output logic [7:0]  issue_operand,
    output logic [15:0] issue_depvals,
    output logic [7:0]  issue_wbs,
    output logic [7:0]  issue_flags,
    output logic [3:0]  issue_robid,
    output logic [2:0]  occupancy
);

    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [7:0]       op_q    [DEPTH];
    logic [7:0]       op_d    [DEPTH];
    logic [7:0]       wbs_q   [DEPTH];
    logic [7:0]       wbs_d   [DEPTH];
    logic [7:0]       flags_q [DEPTH];
    logic [7:0]       flags_d [DEPTH];
    logic [3:0]       robid_q [DEPTH];
    logic [3:0]       robid_d [DEPTH];
    logic [1:0]       rdy_q   [DEPTH];
    logic [1:0]       rdy_d   [DEPTH];
    logic [3:0]       tag_q   [DEPTH][2];
    logic [3:0]       tag_d   [DEPTH][2];
    logic [7:0]       val_q   [DEPTH][2];
    logic [7:0]       val_d   [DEPTH][2];
    // older_q[j][i] = 1 when entry j was dispatched before entry i
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [2:0]       occ_q, occ_d;

    logic             issue_transmit_q;
    logic [7:0]       issue_operand_q;
    logic [15:0]      issue_depvals_q;
    logic [7:0]       issue_wbs_q;
    logic [7:0]       issue_flags_q;
    logic [3:0]       issue_robid_q;

    logic [DEPTH-1:0] eligible;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             older_blk;
    logic             free_found;
    logic [IW-1:0]    free_idx;
    logic             issue_fire;
    logic             disp_fire;

    assign dispatch_ready = ~&valid_q;
    assign issue_fire     = sel_found && !fu_busy && !issue_transmit_q && !flush;
    assign disp_fire      = dispatch_valid && dispatch_ready && !flush;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] && (rdy_q[i] == 2'b11);
        end
    end

    // An eligible entry wins when no other eligible entry is older than it
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        older_blk = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older_blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (eligible[j] && older_q[j][i]) begin
                    older_blk = 1'b1;
                end
            end
            if (eligible[i] && !older_blk && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        wbs_d   = wbs_q;
        flags_d = flags_q;
        robid_d = robid_q;
        rdy_d   = rdy_q;
        tag_d   = tag_q;
        val_d   = val_q;
        older_d = older_q;
        occ_d   = '0;

        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (cdb_valid && valid_q[i] && !rdy_q[i][s] && (tag_q[i][s] == cdb_id)) begin
                    rdy_d[i][s] = 1'b1;
                    val_d[i][s] = cdb_val;
                end
            end
        end

        if (issue_fire) begin
            valid_d[sel_idx] = 1'b0;
        end

        if (disp_fire && free_found) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = d_operand;
            wbs_d[free_idx]   = d_wbs;
            flags_d[free_idx] = d_flags;
            robid_d[free_idx] = d_robid;
            for (int s = 0; s < 2; s++) begin
                tag_d[free_idx][s] = d_src_tag[s*4 +: 4];
                if (d_src_ready[s]) begin
                    rdy_d[free_idx][s] = 1'b1;
                    val_d[free_idx][s] = d_src_val[s*8 +: 8];
                end else if (cdb_valid && (cdb_id == d_src_tag[s*4 +: 4])) begin
                    rdy_d[free_idx][s] = 1'b1;
                    val_d[free_idx][s] = cdb_val;
                end else begin
                    rdy_d[free_idx][s] = 1'b0;
                    val_d[free_idx][s] = '0;
                end
            end
            // Every entry currently held (including one issuing now) is older than the newcomer
            older_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx] = valid_q[j];
            end
        end

        if (flush) begin
            valid_d = '0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + 3'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q          <= '0;
            occ_q            <= '0;
            issue_transmit_q <= 1'b0;
            issue_operand_q  <= '0;
            issue_depvals_q  <= '0;
            issue_wbs_q      <= '0;
            issue_flags_q    <= '0;
            issue_robid_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                wbs_q[i]   <= '0;
                flags_q[i] <= '0;
                robid_q[i] <= '0;
                rdy_q[i]   <= '0;
                older_q[i] <= '0;
                for (int s = 0; s < 2; s++) begin
                    tag_q[i][s] <= '0;
                    val_q[i][s] <= '0;
                end
            end
        end else begin
            valid_q          <= valid_d;
            occ_q            <= occ_d;
            op_q             <= op_d;
            wbs_q            <= wbs_d;
            flags_q          <= flags_d;
            robid_q          <= robid_d;
            rdy_q            <= rdy_d;
            tag_q            <= tag_d;
            val_q            <= val_d;
            older_q          <= older_d;
            issue_transmit_q <= issue_fire;
            if (issue_fire) begin
                issue_operand_q <= op_q[sel_idx];
                issue_depvals_q <= {val_q[sel_idx][1], val_q[sel_idx][0]};
                issue_wbs_q     <= wbs_q[sel_idx];
                issue_flags_q   <= flags_q[sel_idx];
                issue_robid_q   <= robid_q[sel_idx];
            end
        end
    end

    assign issue_transmit = issue_transmit_q;
    assign issue_operand  = issue_operand_q;
    assign issue_depvals  = issue_depvals_q;
    assign issue_wbs      = issue_wbs_q;
    assign issue_flags    = issue_flags_q;
    assign issue_robid    = issue_robid_q;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_mult_rs.sv
// Bench for mult_rs: stimulus pushes expected issues into a scoreboard queue,
// a negedge monitor pops and compares whenever issue_transmit is seen.
module tb_mult_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [7:0]  d_operand;
    logic [1:0]  d_src_ready;
    logic [7:0]  d_src_tag;
    logic [15:0] d_src_val;
    logic [7:0]  d_wbs;
    logic [7:0]  d_flags;
    logic [3:0]  d_robid;
    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [7:0]  cdb_val;
    logic        fu_busy;
    logic        issue_transmit;
    logic [7:0]  issue_operand;
    logic [15:0] issue_depvals;
    logic [7:0]  issue_wbs;
    logic [7:0]  issue_flags;
    logic [3:0]  issue_robid;
    logic [2:0]  occupancy;

    mult_rs #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .d_operand      (d_operand),
        .d_src_ready    (d_src_ready),
        .d_src_tag      (d_src_tag),
        .d_src_val      (d_src_val),
        .d_wbs          (d_wbs),
        .d_flags        (d_flags),
        .d_robid        (d_robid),
        .cdb_valid      (cdb_valid),
        .cdb_id         (cdb_id),
        .cdb_val        (cdb_val),
        .fu_busy        (fu_busy),
        .issue_transmit (issue_transmit),
        .issue_operand  (issue_operand),
        .issue_depvals  (issue_depvals),
        .issue_wbs      (issue_wbs),
        .issue_flags    (issue_flags),
        .issue_robid    (issue_robid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rob;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] wbs;
        logic [7:0] flags;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic exp_t mk(input logic [3:0] rob, input logic [7:0] op,
                                input logic [7:0] a, input logic [7:0] b, input int c);
        exp_t e;
        e.rob   = rob;
        e.op    = op;
        e.a     = a;
        e.b     = b;
        e.wbs   = op ^ 8'h5A;
        e.flags = {4'h0, rob};
        e.cyc   = c;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rob, input logic [7:0] op, input logic [1:0] rdy,
                         input logic [3:0] t0, input logic [3:0] t1,
                         input logic [7:0] a, input logic [7:0] b);
        dispatch_valid = 1'b1;
        d_robid        = rob;
        d_operand      = op;
        d_wbs          = op ^ 8'h5A;
        d_flags        = {4'h0, rob};
        d_src_ready    = rdy;
        d_src_tag      = {t1, t0};
        d_src_val      = {b, a};
    endtask

    task automatic disp_one(input logic [3:0] rob, input logic [7:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        drive(rob, op, 2'b11, 4'h0, 4'h0, a, b);
        tick();
        dispatch_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (issue_transmit === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue: robid %0d issued at cycle %0d, none expected", issue_robid, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("issue_fields",
                      {20'h0, issue_robid, issue_operand, issue_depvals, issue_wbs, issue_flags},
                      {20'h0, mon_e.rob, mon_e.op, mon_e.b, mon_e.a, mon_e.wbs, mon_e.flags});
                if (mon_e.cyc >= 0) check("issue_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    int r;

    initial begin
        rst = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; d_operand = '0; d_src_ready = '0;
        d_src_tag = '0; d_src_val = '0; d_wbs = '0; d_flags = '0; d_robid = '0;
        cdb_valid = 1'b0; cdb_id = '0; cdb_val = '0; fu_busy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_occupancy", occupancy, 0);
        check("rst_ready", dispatch_ready, 1);
        check("rst_transmit", issue_transmit, 0);
        check("rst_data", {issue_robid, issue_operand, issue_depvals, issue_wbs, issue_flags}, 0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // 1: ready op issues two cycles after dispatch
        sb.push_back(mk(4'd3, 8'hA1, 8'd6, 8'd7, cyc + 2));
        disp_one(4'd3, 8'hA1, 8'd6, 8'd7);
        repeat (4) tick();
        @(negedge clk);
        check("t1_occupancy", occupancy, 0);

        // 2: b waits on tag 5; a is ready and carries tag 5 too, so it must ignore the CDB
        tick();
        drive(4'd1, 8'hB2, 2'b01, 4'd5, 4'd5, 8'h03, 8'h00);
        tick();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_id = 4'd6; cdb_val = 8'h55;
        tick();
        @(negedge clk);
        check("t2_waiting_occ", occupancy, 1);
        cdb_id = 4'd5; cdb_val = 8'h09;
        sb.push_back(mk(4'd1, 8'hB2, 8'h03, 8'h09, cyc + 2));
        tick();
        cdb_valid = 1'b0;
        repeat (4) tick();

        // 3: dispatch-time bypass
        drive(4'd6, 8'hC3, 2'b01, 4'd0, 4'd4, 8'h10, 8'h00);
        cdb_valid = 1'b1; cdb_id = 4'd4; cdb_val = 8'h22;
        sb.push_back(mk(4'd6, 8'hC3, 8'h10, 8'h22, cyc + 2));
        tick();
        dispatch_valid = 1'b0; cdb_valid = 1'b0;
        repeat (4) tick();

        // 4: fill while FU busy, fifth dispatch refused, drain in order with idle gaps
        fu_busy = 1'b1;
        disp_one(4'd2, 8'h21, 8'h02, 8'h12);
        disp_one(4'd0, 8'h20, 8'h40, 8'h50);
        disp_one(4'd7, 8'h27, 8'h07, 8'h17);
        disp_one(4'd5, 8'h25, 8'h05, 8'h15);
        @(negedge clk);
        check("t4_full_occ", occupancy, 4);
        check("t4_full_ready", dispatch_ready, 0);
        drive(4'd9, 8'h29, 2'b11, 4'd0, 4'd0, 8'h09, 8'h19);
        tick();
        dispatch_valid = 1'b0;
        @(negedge clk);
        check("t4_fifth_ignored", occupancy, 4);
        tick();
        fu_busy = 1'b0;
        r = cyc;
        sb.push_back(mk(4'd2, 8'h21, 8'h02, 8'h12, r + 1));
        sb.push_back(mk(4'd0, 8'h20, 8'h40, 8'h50, r + 3));
        sb.push_back(mk(4'd7, 8'h27, 8'h07, 8'h17, r + 5));
        sb.push_back(mk(4'd5, 8'h25, 8'h05, 8'h15, r + 7));
        repeat (10) tick();
        @(negedge clk);
        check("t4_drained_occ", occupancy, 0);
        tick();

        // 5: age beats index; dispatch and issue in the same cycle keep occupancy
        fu_busy = 1'b1;
        disp_one(4'd10, 8'h3A, 8'h0A, 8'h1A);
        disp_one(4'd11, 8'h3B, 8'h0B, 8'h1B);
        disp_one(4'd12, 8'h3C, 8'h0C, 8'h1C);
        fu_busy = 1'b0;
        drive(4'd13, 8'h3D, 2'b11, 4'd0, 4'd0, 8'h0D, 8'h1D);
        sb.push_back(mk(4'd10, 8'h3A, 8'h0A, 8'h1A, cyc + 1));
        tick();
        dispatch_valid = 1'b0;
        @(negedge clk);
        check("t5_same_cycle_occ", occupancy, 3);
        fu_busy = 1'b1;
        drive(4'd14, 8'h3E, 2'b11, 4'd0, 4'd0, 8'h0E, 8'h1E);
        tick();
        dispatch_valid = 1'b0;
        @(negedge clk);
        check("t5_refill_occ", occupancy, 4);
        tick();
        fu_busy = 1'b0;
        r = cyc;
        sb.push_back(mk(4'd11, 8'h3B, 8'h0B, 8'h1B, r + 1));
        sb.push_back(mk(4'd12, 8'h3C, 8'h0C, 8'h1C, r + 3));
        sb.push_back(mk(4'd13, 8'h3D, 8'h0D, 8'h1D, r + 5));
        sb.push_back(mk(4'd14, 8'h3E, 8'h0E, 8'h1E, r + 7));
        repeat (10) tick();

        // 6: flush with a same-cycle dispatch and a would-be issue
        fu_busy = 1'b1;
        disp_one(4'd1, 8'h41, 8'h01, 8'h11);
        disp_one(4'd2, 8'h42, 8'h02, 8'h12);
        disp_one(4'd3, 8'h43, 8'h03, 8'h13);
        fu_busy = 1'b0;
        flush = 1'b1;
        drive(4'd15, 8'h4F, 2'b11, 4'd0, 4'd0, 8'h0F, 8'h1F);
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        @(negedge clk);
        check("t6_flush_occ", occupancy, 0);
        check("t6_flush_transmit", issue_transmit, 0);
        repeat (5) tick();
        @(negedge clk);
        check("t6_after_flush_occ", occupancy, 0);
        check("t6_after_flush_ready", dispatch_ready, 1);
        tick();

        // 7: reset while an issue is pending
        fu_busy = 1'b1;
        disp_one(4'd4, 8'h54, 8'h04, 8'h14);
        disp_one(4'd6, 8'h56, 8'h06, 8'h16);
        fu_busy = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_transmit", issue_transmit, 0);
        check("t7_rst_occ", occupancy, 0);
        check("t7_rst_ready", dispatch_ready, 1);
        check("t7_rst_data", {issue_robid, issue_operand, issue_depvals, issue_wbs, issue_flags}, 0);
        repeat (6) tick();
        @(negedge clk);
        check("t7_post_rst_occ", occupancy, 0);

        repeat (3) tick();
        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
